// File: rtl/adc_spi_xfer.sv
`default_nettype none
// ============================================================================
// adc_spi_xfer : SPI engine running one X then one Y conversion on an
// XPT2046/ADS7843-style touch ADC. Optional macro ADC_AVG_EN averages two
// conversions per axis.                                   Revision 1.0
// ============================================================================
module adc_spi_xfer #(
   parameter int unsigned DIV   = 25,
   parameter int unsigned GUARD = 4,
   parameter logic [7:0]  CMD_X = 8'hD0,
   parameter logic [7:0]  CMD_Y = 8'h90
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        Ena_trans,
   input  logic        Fin_trans,
   input  logic        ADC_DOUT,
   output logic        ADC_CS_n,
   output logic        ADC_DCLK,
   output logic        ADC_DIN,
   output logic [11:0] X_data,
   output logic [11:0] Y_data,
   output logic        X_valid,
   output logic        Y_valid
);
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETUP   = 3'd1,
      FRAME_X = 3'd2,
      FRAME_Y = 3'd3,
      RECOVER = 3'd4
   } state_t;

   localparam logic [7:0] DIV_LAST   = 8'(DIV - 1);
   localparam logic [3:0] GUARD_LAST = 4'(GUARD - 1);
   localparam logic [4:0] BIT_LAST   = 5'd23;

   state_t      state_q, state_d;
   logic        ena_q;
   logic [7:0]  div_q, div_d;
   logic [4:0]  bit_q, bit_d;
   logic [3:0]  guard_q, guard_d;
   logic [11:0] shift_q, shift_d;
   logic        cs_n_q, cs_n_d;
   logic        dclk_q, dclk_d;
   logic        din_q, din_d;
   logic [11:0] x_data_q, x_data_d;
   logic [11:0] y_data_q, y_data_d;
   logic        x_valid_q, x_valid_d;
   logic        y_valid_q, y_valid_d;
   logic [11:0] result;
   logic [7:0]  cmd_d;
   logic        in_frame_d;

`ifdef ADC_AVG_EN
   logic        pass_q, pass_d;
   logic [11:0] first_q, first_d;
   logic [12:0] avg_sum;
   assign avg_sum = {1'b0, first_q} + {1'b0, shift_q};
   assign result  = 12'(avg_sum >> 1);
`else
   assign result  = shift_q;
`endif

   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      bit_d     = bit_q;
      guard_d   = guard_q;
      shift_d   = shift_q;
      dclk_d    = 1'b0;
      x_data_d  = x_data_q;
      y_data_d  = y_data_q;
      x_valid_d = x_valid_q;
      y_valid_d = y_valid_q;
`ifdef ADC_AVG_EN
      pass_d    = pass_q;
      first_d   = first_q;
`endif
      if (Fin_trans) begin
         x_valid_d = 1'b0;
         y_valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (Ena_trans && !ena_q) begin
               state_d   = SETUP;
               guard_d   = GUARD_LAST;
               x_valid_d = 1'b0;
               y_valid_d = 1'b0;
            end
         end
         SETUP: begin
            if (!Ena_trans) begin
               state_d = RECOVER;
               guard_d = GUARD_LAST;
            end else if (guard_q == 4'd0) begin
               state_d = FRAME_X;
               div_d   = '0;
               bit_d   = '0;
`ifdef ADC_AVG_EN
               pass_d  = 1'b0;
`endif
            end else begin
               guard_d = guard_q - 4'd1;
            end
         end
         FRAME_X, FRAME_Y: begin
            if (!Ena_trans) begin
               state_d = RECOVER;
               guard_d = GUARD_LAST;
            end else begin
               // First high cycle of DCLK is the sampling point.
               if (dclk_q && div_q == 8'd0 && bit_q >= 5'd9 && bit_q <= 5'd20)
                  shift_d = {shift_q[10:0], ADC_DOUT};
               if (div_q != DIV_LAST) begin
                  div_d  = div_q + 8'd1;
                  dclk_d = dclk_q;
               end else begin
                  div_d  = '0;
                  dclk_d = !dclk_q;
                  if (dclk_q && bit_q != BIT_LAST) begin
                     bit_d = bit_q + 5'd1;
                  end else if (dclk_q) begin
                     bit_d  = '0;
                     dclk_d = 1'b0;
`ifdef ADC_AVG_EN
                     if (!pass_q) begin
                        pass_d  = 1'b1;
                        first_d = shift_q;
                     end else
`endif
                     if (state_q == FRAME_X) begin
                        x_data_d  = result;
                        x_valid_d = 1'b1;
                        state_d   = FRAME_Y;
`ifdef ADC_AVG_EN
                        pass_d    = 1'b0;
`endif
                     end else begin
                        y_data_d  = result;
                        y_valid_d = 1'b1;
                        state_d   = RECOVER;
                        guard_d   = GUARD_LAST;
                     end
                  end
               end
            end
         end
         RECOVER: begin
            if (guard_q == 4'd0) state_d = IDLE;
            else                 guard_d = guard_q - 4'd1;
         end
         default: state_d = IDLE;
      endcase

      // Pin outputs are registered copies of the next-state decode.
      in_frame_d = (state_d == FRAME_X) || (state_d == FRAME_Y);
      cs_n_d     = !(in_frame_d || state_d == SETUP);
      cmd_d      = (state_d == FRAME_Y) ? CMD_Y : CMD_X;
      din_d      = in_frame_d && (bit_d < 5'd8) && cmd_d[3'd7 - bit_d[2:0]];
      if (!in_frame_d) dclk_d = 1'b0;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         ena_q     <= 1'b0;
         div_q     <= '0;
         bit_q     <= '0;
         guard_q   <= '0;
         shift_q   <= '0;
         cs_n_q    <= 1'b1;
         dclk_q    <= 1'b0;
         din_q     <= 1'b0;
         x_data_q  <= '0;
         y_data_q  <= '0;
         x_valid_q <= 1'b0;
         y_valid_q <= 1'b0;
`ifdef ADC_AVG_EN
         pass_q    <= 1'b0;
         first_q   <= '0;
`endif
      end else begin
         state_q   <= state_d;
         ena_q     <= Ena_trans;
         div_q     <= div_d;
         bit_q     <= bit_d;
         guard_q   <= guard_d;
         shift_q   <= shift_d;
         cs_n_q    <= cs_n_d;
         dclk_q    <= dclk_d;
         din_q     <= din_d;
         x_data_q  <= x_data_d;
         y_data_q  <= y_data_d;
         x_valid_q <= x_valid_d;
         y_valid_q <= y_valid_d;
`ifdef ADC_AVG_EN
         pass_q    <= pass_d;
         first_q   <= first_d;
`endif
      end
   end

   assign ADC_CS_n = cs_n_q;
   assign ADC_DCLK = dclk_q;
   assign ADC_DIN  = din_q;
   assign X_data   = x_data_q;
   assign Y_data   = y_data_q;
   assign X_valid  = x_valid_q;
   assign Y_valid  = y_valid_q;
endmodule
`default_nettype wire

// File: tb/tb_adc_spi_xfer.sv
`default_nettype none
// ============================================================================
// tb_adc_spi_xfer : directed bench with a bit-level ADC model for adc_spi_xfer.
// Define ADC_AVG_EN for both DUT and bench to exercise averaging.  Revision 1.0
// ============================================================================
module tb_adc_spi_xfer;
   localparam int DIV   = 2;
   localparam int GUARD = 2;
`ifdef ADC_AVG_EN
   localparam int NPASS = 2;
`else
   localparam int NPASS = 1;
`endif
   localparam int NFR   = 2 * NPASS;
   localparam int X_LAT = GUARD + 48 * DIV * NPASS;
   localparam int Y_LAT = GUARD + 96 * DIV * NPASS;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        Ena_trans = 1'b0;
   logic        Fin_trans = 1'b0;
   logic        ADC_DOUT = 1'b0;
   logic        ADC_CS_n, ADC_DCLK, ADC_DIN, X_valid, Y_valid;
   logic [11:0] X_data, Y_data;

   adc_spi_xfer #(.DIV(DIV), .GUARD(GUARD), .CMD_X(8'hD0), .CMD_Y(8'h90)) dut (
      .CLK(CLK), .RST(RST), .Ena_trans(Ena_trans), .Fin_trans(Fin_trans),
      .ADC_DOUT(ADC_DOUT), .ADC_CS_n(ADC_CS_n), .ADC_DCLK(ADC_DCLK),
      .ADC_DIN(ADC_DIN), .X_data(X_data), .Y_data(Y_data),
      .X_valid(X_valid), .Y_valid(Y_valid)
   );

   always #5 CLK = ~CLK;

   // ADC model: words per frame, data bit for rise k=9..20 is word[20-k].
   logic [11:0] words [4];
   logic        din_log [96];
   int          g = 0, rises = 0, total_rises = 0, dclk_bad = 0;
   logic        prev_dclk = 1'b0, prev_cs = 1'b1;

   function automatic logic adc_bit(input int idx);
      int f, k;
      f = idx / 24;
      k = idx % 24;
      if (f < NFR && k >= 9 && k <= 20) return words[f][20 - k];
      return 1'b0;
   endfunction

   always @(negedge CLK) begin
      if (prev_cs && !ADC_CS_n) begin
         g = 0;
         rises = 0;
      end
      if (ADC_DCLK && !prev_dclk) begin
         if (rises < 96) din_log[rises] = ADC_DIN;
         rises++;
         total_rises++;
      end
      if (!ADC_DCLK && prev_dclk) g++;
      if (ADC_DCLK && ADC_CS_n) dclk_bad++;
      ADC_DOUT  = adc_bit(g);
      prev_dclk = ADC_DCLK;
      prev_cs   = ADC_CS_n;
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   typedef struct {
      logic [11:0] xa, xb, ya, yb;
      logic [11:0] ex, ey;
      bit          fin_at_y;
   } vec_t;
   vec_t vecs [4];

   task automatic load_words(input vec_t v);
`ifdef ADC_AVG_EN
      words[0] = v.xa; words[1] = v.xb; words[2] = v.ya; words[3] = v.yb;
`else
      words[0] = v.xa; words[1] = v.ya; words[2] = 12'h0; words[3] = 12'h0;
`endif
   endtask

   // Called at #1 into an IDLE cycle with Ena_trans low on the previous edge.
   task automatic start_xfer();
      Ena_trans = 1'b1;
      tick();
      chk("start_cs_n", 32'(ADC_CS_n), 32'd0);
      chk("start_flags", 32'({X_valid, Y_valid}), 32'd0);
   endtask

   task automatic run_to_done(input vec_t v);
      int   n;
      bit   seen_x;
      logic [23:0] got;
      logic [7:0]  cmd;
      n = 0;
      seen_x = 1'b0;
      while (!Y_valid && n < 5000) begin
         if (v.fin_at_y && n == Y_LAT - 1) Fin_trans = 1'b1;
         tick();
         n++;
         Fin_trans = 1'b0;
         if (X_valid && !seen_x) begin
            seen_x = 1'b1;
            chk("x_latency", 32'(n), 32'(X_LAT));
            chk("x_data", 32'(X_data), 32'(v.ex));
         end
      end
      chk("x_seen", 32'(seen_x), 32'd1);
      chk("y_latency", 32'(n), 32'(Y_LAT));
      chk("y_data", 32'(Y_data), 32'(v.ey));
      chk("done_cs_n", 32'(ADC_CS_n), 32'd1);
      chk("done_dclk", 32'(ADC_DCLK), 32'd0);
      chk("done_x_valid", 32'(X_valid), v.fin_at_y ? 32'd0 : 32'd1);
      chk("done_y_valid", 32'(Y_valid), 32'd1);
      chk("dclk_rises", 32'(rises), 32'(48 * NPASS));
      for (int f = 0; f < NFR; f++) begin
         for (int k = 0; k < 24; k++) got[23 - k] = din_log[f * 24 + k];
         cmd = (f < NPASS) ? 8'hD0 : 8'h90;
         chk("din_frame", 32'(got), 32'({cmd, 16'h0000}));
      end
   endtask

   task automatic finish_xfer(input vec_t v);
      for (int i = 0; i < GUARD; i++) tick();
      Ena_trans = 1'b0;
      Fin_trans = 1'b1;
      tick();
      Fin_trans = 1'b0;
      chk("fin_flags", 32'({X_valid, Y_valid}), 32'd0);
      chk("fin_hold", 32'({X_data, Y_data}), 32'({v.ex, v.ey}));
   endtask

   initial begin
`ifdef ADC_AVG_EN
      vecs[0] = '{12'h100, 12'h103, 12'h3F0, 12'h3F3, 12'h101, 12'h3F1, 1'b0};
      vecs[1] = '{12'hFFF, 12'hFFE, 12'h000, 12'h001, 12'hFFE, 12'h000, 1'b0};
      vecs[2] = '{12'h001, 12'h002, 12'hFFF, 12'hFFF, 12'h001, 12'hFFF, 1'b0};
      vecs[3] = '{12'h7FF, 12'h800, 12'hA5C, 12'hA5D, 12'h7FF, 12'hA5C, 1'b1};
`else
      vecs[0] = '{12'hA5C, 12'h000, 12'h3F1, 12'h000, 12'hA5C, 12'h3F1, 1'b0};
      vecs[1] = '{12'hFFF, 12'h000, 12'h000, 12'h000, 12'hFFF, 12'h000, 1'b0};
      vecs[2] = '{12'h000, 12'h000, 12'hFFF, 12'h000, 12'h000, 12'hFFF, 1'b0};
      vecs[3] = '{12'h801, 12'h000, 12'h7FE, 12'h000, 12'h801, 12'h7FE, 1'b1};
`endif
      load_words(vecs[0]);

      // Reset and idle.
      for (int i = 0; i < 3; i++) tick();
      RST = 1'b0;
      tick();
      chk("reset_pins", 32'({ADC_CS_n, ADC_DCLK, ADC_DIN}), 32'b100);
      chk("reset_data", 32'({X_data, Y_data}), 32'd0);
      chk("reset_flags", 32'({X_valid, Y_valid}), 32'd0);
      for (int i = 0; i < 50; i++) tick();
      chk("idle_pins", 32'({ADC_CS_n, ADC_DCLK, ADC_DIN}), 32'b100);
      chk("idle_rises", 32'(total_rises), 32'd0);

      // Table of full transfers.
      for (int i = 0; i < 4; i++) begin
         load_words(vecs[i]);
         start_xfer();
         run_to_done(vecs[i]);
         finish_xfer(vecs[i]);
      end

      // Abort inside FRAME_X, then restart from IDLE.
      load_words(vecs[0]);
      start_xfer();
      for (int i = 0; i < 49; i++) tick();
      Ena_trans = 1'b0;
      tick();
      chk("abort_pins", 32'({ADC_CS_n, ADC_DCLK}), 32'b10);
      chk("abort_x_valid", 32'(X_valid), 32'd0);
      chk("abort_x_hold", 32'(X_data), 32'(vecs[3].ex));
      for (int i = 0; i < GUARD; i++) tick();
      chk("abort_recover_cs", 32'(ADC_CS_n), 32'd1);
      start_xfer();
      run_to_done(vecs[0]);
      finish_xfer(vecs[0]);

      // Synchronous reset in FRAME_Y, then a clean transfer.
      load_words(vecs[1]);
      start_xfer();
      for (int i = 0; i < X_LAT + 40; i++) tick();
      chk("pre_rst_x_valid", 32'(X_valid), 32'd1);
      RST = 1'b1;
      tick();
      chk("midrst_pins", 32'({ADC_CS_n, ADC_DCLK, ADC_DIN}), 32'b100);
      chk("midrst_data", 32'({X_data, Y_data}), 32'd0);
      chk("midrst_flags", 32'({X_valid, Y_valid}), 32'd0);
      RST = 1'b0;
      Ena_trans = 1'b0;
      tick();
      start_xfer();
      run_to_done(vecs[1]);
      finish_xfer(vecs[1]);

      chk("dclk_while_cs_high", 32'(dclk_bad), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
